xsw_pkt_arb: RTL
================

Name: xsw_pkt_arb

Overview:
Packet-level output scheduler for one switch egress port. It shares the port between N ingress requesters using round-robin arbitration. A grant is held for a whole packet, from the first beat to the beat flagged last. The selected requester's beats go through a single-entry registered output stage with valid/ready backpressure.

Parameters:
N, 8, number of requesters (N >= 2)
DW, 32, data width per beat

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
en  input  1  permits new packet grants; does not stop a packet already in progress
in_vld  input  N  per-requester beat valid
in_last  input  N  per-requester last-beat flag, qualified by in_vld
in_data  input  N*DW  per-requester beat data; requester i occupies bits [i*DW +: DW]
in_rdy  output  N  per-requester ready; at most one bit set
out_vld  output  1  output beat valid
out_last  output  1  output last-beat flag
out_data  output  DW  output beat data
out_rdy  input  1  downstream ready
cur_gnt  output  N  one-hot index of the requester that owns the port; zero when IDLE
busy  output  1  high in LOCK state

Behaviour:
- Reset is asynchronous, active-low, asserted on the falling edge of rstn. Reset values:
  - state = IDLE, cur_gnt = 0, busy = 0, in_rdy = 0
  - out_vld = 0, out_last = 0, out_data = 0
  - rr pointer = N-1, so requester 0 has highest priority after reset.
- The FSM has two states: IDLE and LOCK.
- IDLE:
  - in_rdy = 0.
  - If en & |in_vld: pick the first requester with in_vld set, searching circularly from pointer+1.
  - The grant is registered. Next cycle: state = LOCK and cur_gnt = one-hot of the winner.
  - If en = 0 or no requester is valid, stay in IDLE.
- LOCK, with owner g:
  - in_rdy[g] = ~out_vld | out_rdy. All other in_rdy bits are 0.
  - A beat transfers when in_vld[g] & in_rdy[g]. The output register loads in_data[g] and in_last[g], and out_vld = 1.
  - A transferred beat with in_last[g] = 1 returns the FSM to IDLE next cycle, sets pointer = g and clears cur_gnt.
  - The FSM cannot re-grant in that same cycle, so there is exactly one idle cycle between packets.
  - If in_vld[g] drops mid-packet, keep the lock, transfer nothing, and do not re-arbitrate.
  - en = 0 has no effect in LOCK.
- Output stage:
  - out_vld, out_data and out_last hold stable while out_vld & ~out_rdy.
  - The register empties (out_vld = 0) when out_rdy is high and no new beat loads.
  - Load and drain in the same cycle sustain one beat per cycle.
- Latency: requester valid at cycle 0 in IDLE → cur_gnt set at cycle 1 → first beat accepted at cycle 1 → out_vld at cycle 2.
- Fairness: any valid requester is granted within N-1 packets of other requesters.
- Reset mid-packet: the packet is dropped, output is cleared and the pointer returns to N-1. No beat is duplicated after reset is released.
- Invariants, checked by simulation-only assertions:
  - cur_gnt is one-hot or zero.
  - in_rdy is a subset of cur_gnt.
  - busy == |cur_gnt.
  - out_data and out_last are stable while out_vld & ~out_rdy.

Test Plan:
- Reset release with in_vld = 8'b1000_0001 and en = 1 → cur_gnt = 8'h01 at cycle 1. After requester 0's last beat: one idle cycle, then cur_gnt = 8'h80.
- All 8 requesters send continuous 2-beat packets with out_rdy = 1 → grant order 0,1,…,7,0. Each packet takes 3 cycles (2 beats plus 1 idle), and out_data matches the source per beat.
- Requester 3 sends a 4-beat packet while out_rdy toggles 1,0,0,1,… → output values are held during stalls. Exactly 4 beats appear, last on beat 4. Requester 5's valid is ignored until the packet ends.
- Requester 2 drops in_vld for 3 cycles mid-packet while requester 6 is valid → cur_gnt stays 8'h04, no beats are output, and the packet resumes afterwards.
- en = 0 with in_vld = 8'hFF → cur_gnt stays 0 and in_rdy = 0. Setting en = 0 during requester 1's packet → the packet completes, then no new grant.
- rstn is pulsed low during beat 2 of a 4-beat packet → all outputs are 0 immediately. After release, requester 0 (valid) wins first and no partial beats are replayed.

Source files
------------

// File: rtl/xsw_pkt_arb_if.sv
// Handshake bundle between the ingress requesters, the egress scheduler and the downstream sink.
// The master side is the environment (requesters plus sink); the slave side is the scheduler.
interface xsw_pkt_arb_if #(
    parameter int N  = 8,
    parameter int DW = 32
);
    logic            en;
    logic [N-1:0]    in_vld;
    logic [N-1:0]    in_last;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_rdy;
    logic            out_vld;
    logic            out_last;
    logic [DW-1:0]   out_data;
    logic            out_rdy;
    logic [N-1:0]    cur_gnt;
    logic            busy;

    modport master (
        output en, in_vld, in_last, in_data, out_rdy,
        input  in_rdy, out_vld, out_last, out_data, cur_gnt, busy
    );

    modport slave (
        input  en, in_vld, in_last, in_data, out_rdy,
        output in_rdy, out_vld, out_last, out_data, cur_gnt, busy
    );
endinterface

// File: rtl/xsw_pkt_arb.sv
// Round-robin packet scheduler for one egress port: a grant is held from first beat to last beat,
// and the owner's beats pass through a single registered output slot with valid/ready backpressure.

module xsw_pkt_arb_chk #(
    parameter int N  = 8,
    parameter int DW = 32
) (
    input logic          clk,
    input logic          rstn,
    input logic [N-1:0]  cur_gnt,
    input logic [N-1:0]  in_rdy,
    input logic          busy,
    input logic          out_vld,
    input logic          out_rdy,
    input logic          out_last,
    input logic [DW-1:0] out_data
);
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(cur_gnt))
        else $error("cur_gnt not one-hot or zero: %b", cur_gnt);
    a_rdy_subset: assert property (@(posedge clk) disable iff (!rstn) ((in_rdy & ~cur_gnt) == '0))
        else $error("in_rdy %b outside cur_gnt %b", in_rdy, cur_gnt);
    a_busy_gnt: assert property (@(posedge clk) disable iff (!rstn) (busy == (|cur_gnt)))
        else $error("busy disagrees with cur_gnt");
    a_out_hold: assert property (@(posedge clk) disable iff (!rstn)
        (out_vld && !out_rdy) |=> ($stable(out_data) && $stable(out_last)))
        else $error("output beat changed while stalled");
endmodule

module xsw_pkt_arb #(
    parameter int N  = 8,
    parameter int DW = 32
) (
    input logic          clk,
    input logic          rstn,
    xsw_pkt_arb_if.slave bus
);
    localparam int PW = $clog2(N);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            out_vld_q, out_vld_d;
    logic            out_last_q, out_last_d;
    logic [DW-1:0]   out_data_q, out_data_d;

    logic [PW-1:0]   owner_s;
    logic [PW-1:0]   win_s;
    logic            win_found_s;
    logic            drain_ok_s;
    logic            xfer_s;

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] ptr, input int k);
        return PW'((int'(ptr) + k) % N);
    endfunction

    // Binary index of the current owner, taken from the one-hot grant.
    always_comb begin
        owner_s = '0;
        for (int i = 0; i < N; i++) begin
            owner_s = owner_s | (gnt_q[i] ? PW'(i) : '0);
        end
    end

    // First valid requester at or after ptr+1, wrapping around.
    always_comb begin
        win_s       = '0;
        win_found_s = 1'b0;
        for (int k = 1; k <= N; k++) begin
            win_s       = (bus.in_vld[rr_idx(ptr_q, k)] && !win_found_s) ? rr_idx(ptr_q, k) : win_s;
            win_found_s = win_found_s | bus.in_vld[rr_idx(ptr_q, k)];
        end
    end

    // The slot can take a beat when empty or when its beat leaves this cycle.
    assign drain_ok_s = ~out_vld_q | bus.out_rdy;
    assign xfer_s     = (state_q == ST_LOCK) & bus.in_vld[owner_s] & drain_ok_s;

    // Next-state: grant in IDLE, release after the last beat, load/drain the output slot.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.en && win_found_s) begin
                    state_d        = ST_LOCK;
                    gnt_d          = '0;
                    gnt_d[win_s]   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end
            ST_LOCK: begin
                if (xfer_s && bus.in_last[owner_s]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    ptr_d   = owner_s;
                end else begin
                    state_d = ST_LOCK;
                    gnt_d   = gnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
        if (xfer_s) begin
            out_vld_d  = 1'b1;
            out_last_d = bus.in_last[owner_s];
            out_data_d = bus.in_data[owner_s*DW +: DW];
        end else if (bus.out_rdy) begin
            out_vld_d = 1'b0;
        end else begin
            out_vld_d = out_vld_q;
        end
    end

    // All state and outputs are registered; pointer N-1 makes requester 0 first after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            ptr_q      <= PW'(N - 1);
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            out_data_q <= out_data_d;
        end
    end

    assign bus.in_rdy   = (state_q == ST_LOCK) ? (gnt_q & {N{drain_ok_s}}) : '0;
    assign bus.cur_gnt  = gnt_q;
    assign bus.busy     = (state_q == ST_LOCK);
    assign bus.out_vld  = out_vld_q;
    assign bus.out_last = out_last_q;
    assign bus.out_data = out_data_q;

    xsw_pkt_arb_chk #(.N(N), .DW(DW)) u_chk (
        .clk      (clk),
        .rstn     (rstn),
        .cur_gnt  (bus.cur_gnt),
        .in_rdy   (bus.in_rdy),
        .busy     (bus.busy),
        .out_vld  (bus.out_vld),
        .out_rdy  (bus.out_rdy),
        .out_last (bus.out_last),
        .out_data (bus.out_data)
    );
endmodule
